// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the UART console blocks: FSM encoding, status layout,
// default register addresses.
package uart_defs;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   localparam int STAT_EMPTY   = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_OVF     = 2;
   localparam int STAT_BUSY    = 3;
   localparam int STAT_CNT_LSB = 4;

   localparam logic [31:0] DEF_TX_ADDR   = 32'hFFFF_0000;
   localparam logic [31:0] DEF_STAT_ADDR = 32'hFFFF_0004;

   function automatic logic [31:0] pack_status(input logic        empty,
                                               input logic        full,
                                               input logic        ovf,
                                               input logic        busy,
                                               input logic [31:0] count);
      logic [31:0] s;
      s = count << STAT_CNT_LSB;
      s[STAT_EMPTY] = empty;
      s[STAT_FULL]  = full;
      s[STAT_OVF]   = ovf;
      s[STAT_BUSY]  = busy;
      return s;
   endfunction

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous FIFO with occupancy count; shared by the UART TX and RX blocks.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage carries no reset; only pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TX/status register decode, byte FIFO and
// 8N1 serializer with registered line outputs.
module uart_tx_mmio
   import uart_defs::*;
#(
   parameter int          CLKS_PER_BIT = 217,
   parameter int          FIFO_DEPTH   = 16,
   parameter logic [31:0] TX_ADDR      = DEF_TX_ADDR,
   parameter logic [31:0] STAT_ADDR    = DEF_STAT_ADDR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_write_en,
   input  logic [31:0] mem_write_addr,
   input  logic [31:0] mem_write_data,
   input  logic        mem_read_en,
   input  logic [31:0] mem_read_addr,
   output logic [31:0] mem_read_data,
   output logic        rd_hit,
   output logic        tx,
   output logic        tx_busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);

   logic        push_hit, clr_hit, stat_rd;
   logic        fifo_full, fifo_empty, fifo_pop;
   logic [7:0]  fifo_rdata;
   logic [AW:0] fifo_count;
   logic [31:0] status;

   logic        ovf_q, ovf_d;
   logic        rd_hit_q, rd_hit_d;
   logic [31:0] rdata_q, rdata_d;

   tx_state_e     state_q;
   logic [CW-1:0] baud_q;
   logic [2:0]    bit_idx_q;
   logic [7:0]    shreg_q;
   logic          tx_q, busy_q;

   logic unused_wdata;
   assign unused_wdata = ^mem_write_data[31:8];

   assign push_hit = mem_write_en && (mem_write_addr == TX_ADDR);
   assign clr_hit  = mem_write_en && (mem_write_addr == STAT_ADDR);
   assign stat_rd  = mem_read_en && (mem_read_addr == STAT_ADDR);
   assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_hit),
      .wdata (mem_write_data[7:0]),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign status = pack_status(fifo_empty, fifo_full, ovf_q, busy_q, 32'(fifo_count));

   // Full is judged on the pre-edge count, so a same-cycle pop never rescues the byte.
   always_comb begin
      ovf_d = ovf_q;
      if (push_hit && fifo_full) ovf_d = 1'b1;
      else if (clr_hit)          ovf_d = 1'b0;
      rd_hit_d = stat_rd;
      rdata_d  = stat_rd ? status : 32'h0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q    <= 1'b0;
         rd_hit_q <= 1'b0;
         rdata_q  <= 32'h0;
      end else begin
         ovf_q    <= ovf_d;
         rd_hit_q <= rd_hit_d;
         rdata_q  <= rdata_d;
      end
   end

   // tx_q is updated on each state transition so the line matches the state it enters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  shreg_q <= fifo_rdata;
                  baud_q  <= BAUD_RELOAD;
                  state_q <= ST_START;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            ST_START: begin
               if (baud_q == '0) begin
                  baud_q    <= BAUD_RELOAD;
                  bit_idx_q <= '0;
                  state_q   <= ST_DATA;
                  tx_q      <= shreg_q[0];
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            ST_DATA: begin
               if (baud_q == '0) begin
                  baud_q  <= BAUD_RELOAD;
                  shreg_q <= shreg_q >> 1;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= ST_STOP;
                     tx_q    <= 1'b1;
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                     tx_q      <= shreg_q[1];
                  end
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            ST_STOP: begin
               if (baud_q == '0) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  baud_q <= baud_q - 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mem_read_data = rdata_q;
   assign rd_hit        = rd_hit_q;
   assign tx            = tx_q;
   assign tx_busy       = busy_q;

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped console transmitter attached to the `pipelined_cpu` data port. It consumes the CPU's store stream (`mem_write_*`) and its second read port (`mem_read1_*`), and queues bytes written to a TX register into a FIFO. It serializes those bytes as 8N1 UART frames and returns a status word on reads of a status register. It sits beside main memory; the top level muxes `mem_read1_data` on `rd_hit`.

## Interface

Parameters:

- `CLKS_PER_BIT`, 217, clock cycles per UART bit, minimum 2.
- `FIFO_DEPTH`, 16, TX FIFO entries, power of two.
- `TX_ADDR`, 32'hFFFF_0000, store address that enqueues `data[7:0]`.
- `STAT_ADDR`, 32'hFFFF_0004, status register address. A read returns status; a store clears overflow.

Ports:

- `clk` in 1: single clock. All state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_write_en` in 1: CPU store strobe.
- `mem_write_addr` in 32: store address.
- `mem_write_data` in 32: store data.
- `mem_read_en` in 1: CPU read strobe.
- `mem_read_addr` in 32: CPU data-read address (`mem_read1_addr`).
- `mem_read_data` out 32: registered status word; 0 when not hit.
- `rd_hit` out 1: registered; 1 when `mem_read_data` is valid from this block.
- `tx` out 1: serial line, idle high.
- `tx_busy` out 1: 1 in START, DATA and STOP.

## Operation

- **Push**
  - Condition: `mem_write_en && mem_write_addr == TX_ADDR`.
  - If the FIFO is not full at the start of the cycle, `mem_write_data[7:0]` is enqueued.
  - If full, the byte is dropped and sticky `overflow` is set. This holds even if a pop occurs in the same cycle.
- **Overflow clear**
  - Condition: `mem_write_en && mem_write_addr == STAT_ADDR`.
  - Clears `overflow`; data is ignored.
  - Set and clear can never coincide, because there is one write port.
- **Status word**
  - bit0: empty.
  - bit1: full.
  - bit2: overflow.
  - bit3: `tx_busy`.
  - bits[8:4]: FIFO count, range 0..FIFO_DEPTH.
  - Other bits: 0.
- **Read**
  - Registered: `rd_hit <= mem_read_en && mem_read_addr == STAT_ADDR`.
  - `mem_read_data <= hit ? status : 0`.
  - Status is sampled in the request cycle, before that cycle's push or pop.
- **Transmit FSM**
  - States: IDLE, START, DATA, STOP.
  - IDLE: `tx=1`. If the FIFO is non-empty, pop into `shreg`, load baud counter with `CLKS_PER_BIT-1`, go to START.
  - START: `tx=0` until counter hits 0. Then reload, set bit index 0, go to DATA.
  - DATA: `tx=shreg[0]`. On counter 0, shift right, reload and increment the index. After index 7 expires, go to STOP.
  - STOP: `tx=1` for `CLKS_PER_BIT` cycles, then IDLE.
- **FIFO**: no bypass. A byte written into an empty FIFO is popped the following cycle.

## Timing

- **Reset values**
  - `tx=1`, `tx_busy=0`, `rd_hit=0`, `mem_read_data=0`.
  - FIFO empty, `overflow=0`, state IDLE, counter 0.
- **Push-to-line latency**: store in cycle N → pop in N+1 → `tx` falls in N+2.
- **Frame length**: 10×`CLKS_PER_BIT` cycles of START+DATA+STOP.
- **Back-to-back frames**: one IDLE cycle (`tx=1`) between frames, giving a period of 10×`CLKS_PER_BIT`+1.
- **Read latency**: 1 cycle, matching main-memory latency on read port 1.
- **Pointer and count arithmetic**
  - Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.
  - Count is one bit wider.
  - Simultaneous push and pop leaves the count unchanged.
- **Reset mid-frame**: `tx` is 1 on the first cycle after `rst` is sampled. In-flight and queued bytes are lost.
- **Halt**: CPU halt has no effect. Queued bytes drain.

## Structure

- Shared package `uart_defs`:
  - FSM state encoding (2-bit).
  - Status bit positions.
  - Default addresses.
- Sub-module `sync_fifo`:
  - Parameters: width 8, depth.
  - Ports: push/pop/data, full/empty/count.
  - Reused later by an RX block.
- The top of this block holds:
  - Address decode.
  - Overflow flag.
  - Read register.
  - FSM with baud counter and shift register.

## Test plan

All scenarios use `CLKS_PER_BIT=4`.

- **Reset**: hold `rst` 2 cycles, release, read STAT_ADDR → next cycle `rd_hit=1`, `mem_read_data=32'h1`; `tx=1`.
- **Single byte**: store 0x55 to TX_ADDR at cycle 0 → `tx` falls at cycle 2; data bits 1,0,1,0,1,0,1,0 each 4 cycles; stop high; `tx_busy` low at cycle 42.
- **Overflow**: 18 consecutive TX stores starting idle → 17 bytes transmitted in order; the 18th is dropped; status read shows `overflow=1`, `count=16` right after the burst.
- **Overflow clear and decode**:
  - Store to STAT_ADDR → next status read has bit2=0.
  - Read of 32'h0000_1000 → `rd_hit=0`, `mem_read_data=0`.
- **Back-to-back frames**: two queued bytes → exactly one idle-high cycle between STOP end and the second START; frame period 41 cycles.
- **Reset mid-frame**: assert `rst` in the DATA state of the first of 3 queued bytes → `tx=1`, status 32'h1, no further frames.
